// File: rtl/memctrl_mc.sv
// -----------------------------------------------------------------------------
// memctrl_mc
//
// Multi-channel, multi-byte front end to the 8-bit RAM/IO bus. Arbitrates
// between NCH requesters, serialises the winning request into 1, 2 or 4 byte
// accesses, and returns reads as little-endian words, zero-extended.
// The RAM returns read data one cycle after its address is driven. A one-deep
// capture stage (vld_p1/idx_p1) handles that latency.
//
// Parameters
//   NCH        number of requester channels (1..8); channel 0 is bit/slice 0
//   PRIO_MODE  0 = fixed priority (lowest index wins), 1 = round-robin
//   AW         address width
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   rdy        global ready; low freezes the controller
//   req_i      per-channel request level
//   rw_i       per-channel direction, 1 = write
//   addr_i     per-channel start byte address (AW bits per channel)
//   len_i      per-channel length code: 0 = 1 B, 1 = 2 B, 2/3 = 4 B
//   wdata_i    per-channel write word, byte k in [8k+7:8k]
//   ack_o      one-cycle completion pulse to the granted channel
//   rdata_o    assembled read word, meaningful while ack_o is high
//   gnt_o      one-hot current owner, 0 when idle
//   busy_o     high whenever the FSM is not IDLE
//   ram_din    RAM read byte for the address driven in the previous cycle
//   ram_dout   RAM write byte
//   ram_a      RAM address
//   ram_wr     RAM write strobe
// -----------------------------------------------------------------------------
module memctrl_mc #(
  parameter int NCH       = 2,
  parameter int PRIO_MODE = 0,
  parameter int AW        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [NCH-1:0]    req_i,
  input  logic [NCH-1:0]    rw_i,
  input  logic [NCH*AW-1:0] addr_i,
  input  logic [NCH*2-1:0]  len_i,
  input  logic [NCH*32-1:0] wdata_i,
  output logic [NCH-1:0]    ack_o,
  output logic [31:0]       rdata_o,
  output logic [NCH-1:0]    gnt_o,
  output logic              busy_o,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [AW-1:0]     ram_a,
  output logic              ram_wr
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Control registers
  logic [NCH-1:0] gnt_r;
  logic [PW-1:0]  rr_ptr;
  logic           rw_r;
  logic [1:0]     last_k;
  logic [1:0]     k_p0;
  logic           vld_p1;
  logic [1:0]     idx_p1;

  // Data registers
  logic [AW-1:0]  addr_r;
  logic [31:0]    wdata_r;
  logic [31:0]    rdata_r;

  // Arbitration results
  logic           any_req;
  logic [PW-1:0]  win_idx;
  logic [PW-1:0]  lo_idx;
  logic [PW-1:0]  hi_idx;
  logic           hi_found;

  logic           grant;
  logic           issue;
  logic           issue_rd;

  // Length code to index of the final byte
  function automatic logic [1:0] last_index(input logic [1:0] len);
    logic [1:0] r;
    case (len)
      2'd0:    r = 2'd0;
      2'd1:    r = 2'd1;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Arbiter. The loop runs downward, so the last hit is the lowest index.
  // lo_idx is the lowest requester overall. hi_idx is the lowest requester
  // strictly above the round-robin pointer. When no requester sits above the
  // pointer, round-robin wraps to lo_idx.
  // ---------------------------------------------------------------------------
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = PW'(i);
        if (i > int'(rr_ptr)) begin
          hi_idx   = PW'(i);
          hi_found = 1'b1;
        end
      end
    end
    if (PRIO_MODE != 0 && hi_found) begin
      win_idx = hi_idx;
    end else begin
      win_idx = lo_idx;
    end
  end

  assign any_req  = |req_i;
  assign grant    = (state == IDLE) && rdy && any_req;
  assign issue    = (state == XFER) && rdy;
  assign issue_rd = issue && !rw_r;

  // ---------------------------------------------------------------------------
  // FSM state register and control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      gnt_r  <= '0;
      rr_ptr <= PW'(NCH - 1);
      rw_r   <= 1'b0;
      last_k <= 2'd0;
      k_p0   <= 2'd0;
      vld_p1 <= 1'b0;
      idx_p1 <= 2'd0;
    end else begin
      state <= state_nxt;

      // vld_p1 is updated even while rdy is low. The byte issued in the last
      // ready cycle is captured once, and the flag then clears.
      vld_p1 <= issue_rd;
      if (issue_rd) begin
        idx_p1 <= k_p0;
      end

      if (grant) begin
        gnt_r  <= NCH'(1) << win_idx;
        rr_ptr <= win_idx;
        rw_r   <= rw_i[win_idx];
        last_k <= last_index(len_i[int'(win_idx)*2 +: 2]);
        k_p0   <= 2'd0;
      end else if (issue) begin
        k_p0 <= k_p0 + 2'd1;
      end

      if ((state == DONE) && rdy) begin
        gnt_r <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch and read-byte capture (data path, no reset needed).
  // rdata_r is cleared at grant, so unread bytes come back as zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_r  <= addr_i[int'(win_idx)*AW +: AW];
      wdata_r <= wdata_i[int'(win_idx)*32 +: 32];
      rdata_r <= 32'h0;
    end else if (vld_p1) begin
      rdata_r[{idx_p1, 3'b000} +: 8] <= ram_din;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and bus/handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    ram_a     = '0;
    ram_wr    = 1'b0;
    ram_dout  = 8'h00;
    ack_o     = '0;
    rdata_o   = 32'h0;
    busy_o    = (state != IDLE);

    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (issue) begin
          ram_a = addr_r + AW'(k_p0);
          if (rw_r) begin
            ram_wr   = 1'b1;
            ram_dout = wdata_r[{k_p0, 3'b000} +: 8];
          end
          // Leave as soon as the final byte is out, so no extra address is
          // ever presented to side-effecting IO locations.
          if (k_p0 == last_k) begin
            state_nxt = rw_r ? DONE : TAIL;
          end
        end
      end
      TAIL: begin
        if (rdy) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        rdata_o = rdata_r;
        if (rdy) begin
          ack_o     = gnt_r;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign gnt_o = gnt_r;

endmodule

// File: tb/tb_memctrl_mc.sv
module tb_memctrl_mc;

  localparam int NCH = 2;
  localparam int AW  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rdy = 1'b1;
  logic [NCH-1:0]    req = '0;
  logic [NCH-1:0]    rw = '0;
  logic [NCH*AW-1:0] addr = '0;
  logic [NCH*2-1:0]  len = '0;
  logic [NCH*32-1:0] wdata = '0;
  logic [7:0]        ram_din = 8'h00;

  logic [NCH-1:0] ack0, gnt0;
  logic [31:0]    rdata0;
  logic           busy0;
  logic [7:0]     dout0;
  logic [AW-1:0]  a0;
  logic           wr0;

  logic [NCH-1:0] ack1, gnt1;
  logic [31:0]    rdata1;
  logic           busy1;
  logic [7:0]     dout1;
  logic [AW-1:0]  a1;
  logic           wr1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  memctrl_mc #(.NCH(NCH), .PRIO_MODE(0), .AW(AW)) dut0 (
    .clk(clk), .rst(rst), .rdy(rdy), .req_i(req), .rw_i(rw), .addr_i(addr),
    .len_i(len), .wdata_i(wdata), .ack_o(ack0), .rdata_o(rdata0), .gnt_o(gnt0),
    .busy_o(busy0), .ram_din(ram_din), .ram_dout(dout0), .ram_a(a0), .ram_wr(wr0)
  );

  memctrl_mc #(.NCH(NCH), .PRIO_MODE(1), .AW(AW)) dut1 (
    .clk(clk), .rst(rst), .rdy(rdy), .req_i(req), .rw_i(rw), .addr_i(addr),
    .len_i(len), .wdata_i(wdata), .ack_o(ack1), .rdata_o(rdata1), .gnt_o(gnt1),
    .busy_o(busy1), .ram_din(ram_din), .ram_dout(dout1), .ram_a(a1), .ram_wr(wr1)
  );

  // RAM contents: 0x100..0x103 hold 11 22 33 44; elsewhere a[7:0]^0xA5^a[23:16]
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    logic [7:0] r;
    case (a)
      32'h100: r = 8'h11;
      32'h101: r = 8'h22;
      32'h102: r = 8'h33;
      32'h103: r = 8'h44;
      default: r = a[7:0] ^ 8'hA5 ^ a[23:16];
    endcase
    return r;
  endfunction

  // One-cycle read latency: data for the address of cycle n appears in n+1
  always @(posedge clk) ram_din <= ram_byte(a0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic ch, input logic w, input logic [31:0] a,
                         input logic [1:0] l, input logic [31:0] d);
    if (ch) begin
      req[1] = 1'b1; rw[1] = w; addr[63:32] = a; len[3:2] = l; wdata[63:32] = d;
    end else begin
      req[0] = 1'b1; rw[0] = w; addr[31:0] = a; len[1:0] = l; wdata[31:0] = d;
    end
  endtask

  task automatic clear_req();
    req = '0; rw = '0; addr = '0; len = '0; wdata = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    rdy = 1'b1;
    clear_req();
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rdy = 1'b1;
    set_req(1'b0, 1'b1, 32'h10, 2'd0, 32'hAA);
    repeat (3) step();
    if ({busy0, gnt0, ack0, wr0} !== 6'b0 || a0 !== 32'h0 || dout0 !== 8'h0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b gnt=%b ack=%b wr=%b a=%h dout=%h expected all zero",
               busy0, gnt0, ack0, wr0, a0, dout0);
    end
    checks++;
    if (rdata0 !== 32'h0 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_rdata: rdata=%h busy1=%b expected 0/0", rdata0, busy1);
    end
    checks++;
    clear_req();
    rst = 1'b1;
    step();
    if ({busy0, gnt0} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle: busy=%b gnt=%b expected 0/00", busy0, gnt0);
    end
    checks++;
  endtask

  task automatic test_read4();
    set_req(1'b0, 1'b0, 32'h100, 2'd2, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (a0 !== 32'h100 + 32'(c - 1) || wr0 !== 1'b0 || ack0 !== 2'b00) begin
        fails++;
        $display("FAIL read4_issue c%0d: a=%h wr=%b ack=%b expected a=%h wr=0 ack=00",
                 c, a0, wr0, ack0, 32'h100 + 32'(c - 1));
      end
      checks++;
    end
    step();
    if ({busy0, ack0} !== 3'b100 || a0 !== 32'h0) begin
      fails++;
      $display("FAIL read4_tail: busy=%b ack=%b a=%h expected 1/00/0", busy0, ack0, a0);
    end
    checks++;
    step();
    if (ack0 !== 2'b01 || rdata0 !== 32'h44332211) begin
      fails++;
      $display("FAIL read4_ack: ack=%b rdata=%h expected 01/44332211", ack0, rdata0);
    end
    checks++;
    step();
    clear_req();
    if ({busy0, gnt0, ack0} !== 5'b0) begin
      fails++;
      $display("FAIL read4_idle: busy=%b gnt=%b ack=%b expected zero", busy0, gnt0, ack0);
    end
    checks++;
  endtask

  task automatic test_write2();
    set_req(1'b1, 1'b1, 32'h200, 2'd1, 32'h0000BEEF);
    step();
    if (a0 !== 32'h200 || dout0 !== 8'hEF || wr0 !== 1'b1 || gnt0 !== 2'b10) begin
      fails++;
      $display("FAIL write2_b0: a=%h dout=%h wr=%b gnt=%b expected 200/EF/1/10", a0, dout0, wr0, gnt0);
    end
    checks++;
    step();
    if (a0 !== 32'h201 || dout0 !== 8'hBE || wr0 !== 1'b1 || ack0 !== 2'b00) begin
      fails++;
      $display("FAIL write2_b1: a=%h dout=%h wr=%b ack=%b expected 201/BE/1/00", a0, dout0, wr0, ack0);
    end
    checks++;
    step();
    if (ack0 !== 2'b10 || wr0 !== 1'b0 || a0 !== 32'h0) begin
      fails++;
      $display("FAIL write2_ack: ack=%b wr=%b a=%h expected 10/0/0", ack0, wr0, a0);
    end
    checks++;
    step();
    clear_req();
  endtask

  task automatic test_read1();
    set_req(1'b1, 1'b0, 32'h101, 2'd0, 32'h0);
    step();
    if (a0 !== 32'h101 || wr0 !== 1'b0 || ack0 !== 2'b00) begin
      fails++;
      $display("FAIL read1_issue: a=%h wr=%b ack=%b expected 101/0/00", a0, wr0, ack0);
    end
    checks++;
    step();
    if (ack0 !== 2'b00 || a0 !== 32'h0) begin
      fails++;
      $display("FAIL read1_tail: ack=%b a=%h expected 00/0", ack0, a0);
    end
    checks++;
    step();
    if (ack0 !== 2'b10 || rdata0 !== 32'h00000022) begin
      fails++;
      $display("FAIL read1_ack: ack=%b rdata=%h expected 10/00000022", ack0, rdata0);
    end
    checks++;
    step();
    clear_req();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [4];
    exp_a = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    set_req(1'b0, 1'b0, 32'hFFFFFFFE, 2'd3, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (a0 !== exp_a[c-1] || busy0 !== 1'b1) begin
        fails++;
        $display("FAIL wrap_addr c%0d: a=%h busy=%b expected %h/1", c, a0, busy0, exp_a[c-1]);
      end
      checks++;
    end
    repeat (2) step();
    if (ack0 !== 2'b01 || rdata0 !== 32'hA4A5A5A4) begin
      fails++;
      $display("FAIL wrap_ack: ack=%b rdata=%h expected 01/A4A5A5A4", ack0, rdata0);
    end
    checks++;
    step();
    clear_req();
  endtask

  task automatic test_rdy_pause();
    logic [31:0] exp_a [8];
    exp_a = '{32'h30000, 32'h30001, 32'h0, 32'h0, 32'h30002, 32'h30003, 32'h0, 32'h0};
    set_req(1'b0, 1'b0, 32'h30000, 2'd2, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      step();
      rdy = (c == 3 || c == 4) ? 1'b0 : 1'b1;
      #1;
      if (a0 !== exp_a[c-1] || wr0 !== 1'b0 || busy0 !== 1'b1 ||
          ack0 !== ((c == 8) ? 2'b01 : 2'b00)) begin
        fails++;
        $display("FAIL pause_c%0d: a=%h wr=%b busy=%b ack=%b expected a=%h wr=0 busy=1 ack=%b",
                 c, a0, wr0, busy0, ack0, exp_a[c-1], (c == 8) ? 2'b01 : 2'b00);
      end
      checks++;
    end
    if (rdata0 !== 32'hA5A4A7A6) begin
      fails++;
      $display("FAIL pause_rdata: rdata=%h expected A5A4A7A6", rdata0);
    end
    checks++;
    step();
    clear_req();
    rdy = 1'b1;
  endtask

  task automatic test_done_pause();
    set_req(1'b1, 1'b1, 32'h40, 2'd0, 32'h5C);
    step();
    if (a0 !== 32'h40 || dout0 !== 8'h5C || wr0 !== 1'b1) begin
      fails++;
      $display("FAIL donep_issue: a=%h dout=%h wr=%b expected 40/5C/1", a0, dout0, wr0);
    end
    checks++;
    step();
    rdy = 1'b0;
    #1;
    if (ack0 !== 2'b00 || busy0 !== 1'b1) begin
      fails++;
      $display("FAIL donep_hold: ack=%b busy=%b expected 00/1", ack0, busy0);
    end
    checks++;
    step();
    rdy = 1'b1;
    #1;
    if (ack0 !== 2'b10) begin
      fails++;
      $display("FAIL donep_ack: ack=%b expected 10", ack0);
    end
    checks++;
    step();
    clear_req();
  endtask

  task automatic test_back_to_back();
    set_req(1'b0, 1'b0, 32'h100, 2'd2, 32'h0);
    for (int c = 1; c <= 13; c++) begin
      step();
      if (ack0 !== ((c == 6 || c == 13) ? 2'b01 : 2'b00)) begin
        fails++;
        $display("FAIL b2b_ack c%0d: ack=%b expected %b", c, ack0,
                 (c == 6 || c == 13) ? 2'b01 : 2'b00);
      end
      checks++;
      if (c == 8 && a0 !== 32'h100) begin
        fails++;
        $display("FAIL b2b_reissue: a=%h expected 00000100", a0);
      end
      if (c == 8) checks++;
    end
    if (rdata0 !== 32'h44332211) begin
      fails++;
      $display("FAIL b2b_rdata: rdata=%h expected 44332211", rdata0);
    end
    checks++;
    step();
    clear_req();
  endtask

  task automatic test_reset_mid();
    set_req(1'b0, 1'b1, 32'h400, 2'd2, 32'h44332211);
    repeat (3) step();
    if (a0 !== 32'h402 || dout0 !== 8'h33 || wr0 !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_b2: a=%h dout=%h wr=%b expected 402/33/1", a0, dout0, wr0);
    end
    checks++;
    #2;
    rst = 1'b0;
    #1;
    if (wr0 !== 1'b0 || a0 !== 32'h0 || busy0 !== 1'b0 || gnt0 !== 2'b00) begin
      fails++;
      $display("FAIL rstmid_async: wr=%b a=%h busy=%b gnt=%b expected 0/0/0/00", wr0, a0, busy0, gnt0);
    end
    checks++;
    step();
    clear_req();
    step();
    rst = 1'b1;
    step();
    if (ack0 !== 2'b00 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_noack: ack=%b busy=%b expected 00/0", ack0, busy0);
    end
    checks++;
    set_req(1'b1, 1'b1, 32'h500, 2'd0, 32'h34);
    step();
    if (a0 !== 32'h500 || dout0 !== 8'h34 || wr0 !== 1'b1 || gnt0 !== 2'b10) begin
      fails++;
      $display("FAIL rstmid_next: a=%h dout=%h wr=%b gnt=%b expected 500/34/1/10", a0, dout0, wr0, gnt0);
    end
    checks++;
    step();
    if (ack0 !== 2'b10) begin
      fails++;
      $display("FAIL rstmid_nextack: ack=%b expected 10", ack0);
    end
    checks++;
    step();
    clear_req();
  endtask

  task automatic test_arbitration();
    logic [1:0] e;
    apply_reset();
    set_req(1'b0, 1'b1, 32'h10, 2'd0, 32'hAA);
    set_req(1'b1, 1'b1, 32'h20, 2'd0, 32'hBB);
    for (int t = 0; t < 4; t++) begin
      e = (t % 2 == 0) ? 2'b01 : 2'b10;
      step();
      if (gnt0 !== 2'b01 || a0 !== 32'h10 || dout0 !== 8'hAA) begin
        fails++;
        $display("FAIL fixed_gnt t%0d: gnt=%b a=%h dout=%h expected 01/10/AA", t, gnt0, a0, dout0);
      end
      checks++;
      if (gnt1 !== e || a1 !== ((t % 2 == 0) ? 32'h10 : 32'h20)) begin
        fails++;
        $display("FAIL rr_gnt t%0d: gnt=%b a=%h expected %b", t, gnt1, a1, e);
      end
      checks++;
      step();
      if (ack1 !== e || ack0 !== 2'b01) begin
        fails++;
        $display("FAIL rr_ack t%0d: ack1=%b ack0=%b expected %b/01", t, ack1, ack0, e);
      end
      checks++;
      step();
    end
    clear_req();
  endtask

  initial begin
    test_reset();
    test_read4();
    test_write2();
    test_read1();
    test_wrap();
    test_rdy_pause();
    test_done_pause();
    test_back_to_back();
    test_reset_mid();
    test_arbitration();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
